ct_rd_arb: RTL and testbench

- Round-robin arbiter that shares the single read port of ct_mem between NUM_REQ crack engines. Used so that parallel crack instances can search disjoint key ranges against one ciphertext copy.
- Sits between the engines' ciphertext read interfaces and ct_mem. ct_mem is altsyncram with a registered address and wren tied low.
- Adds a req/gnt handshake and a tagged, latency-matched read-valid return path.

---
 rtl/ct_arb_pkg.sv | 36 +++
 rtl/rr_pick_nxt.sv | 33 +++
 rtl/ct_rd_arb.sv | 83 ++++++++
 tb/tb_ct_rd_arb.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ct_arb_pkg.sv
// Shared types and the round-robin pick function for the ciphertext-memory
// read arbiter and the planned key-range dispatcher.
package ct_arb_pkg;

  localparam int CT_ADDR_W = 8;
  localparam int CT_DATA_W = 8;
  localparam int CT_RD_LAT = 1;

  // Widest requester set the picker supports; narrower users zero-extend.
  localparam int MAX_REQ   = 8;
  localparam int MAX_PTR_W = 3;

  typedef logic [CT_ADDR_W-1:0] ct_addr_t;
  typedef logic [CT_DATA_W-1:0] ct_data_t;
  typedef logic [MAX_REQ-1:0]   req_vec_t;

  // One-hot pick of the first asserted req at or after ptr, wrapping modulo n.
  function automatic req_vec_t rr_pick(input req_vec_t req,
                                       input logic [MAX_PTR_W-1:0] ptr,
                                       input int unsigned n);
    req_vec_t    pick;
    logic        found;
    int unsigned slot;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      slot = (32'(ptr) + k) % n;
      if (!found && (k < n) && req[slot[MAX_PTR_W-1:0]]) begin
        pick[slot[MAX_PTR_W-1:0]] = 1'b1;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_pick_nxt.sv
// Pure round-robin priority picker: request vector and pointer in,
// one-hot grant and its binary index out. No state.
module rr_pick_nxt
  import ct_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  req_vec_t             req_ext;
  req_vec_t             pick;
  logic [MAX_PTR_W-1:0] ptr_ext;

  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req;
    ptr_ext          = '0;
    ptr_ext[PW-1:0]  = ptr;
    pick             = rr_pick(req_ext, ptr_ext, N);
    gnt              = pick[N-1:0];
    idx              = '0;
    // Bits above N never fire, so scanning all of them is harmless.
    for (int i = 0; i < MAX_REQ; i++) begin
      if (pick[i]) idx = PW'(i);
    end
  end

endmodule

// File: rtl/ct_rd_arb.sv
// Round-robin sharing of the single ct_mem read port between NUM_REQ crack
// engines, with a latency-matched one-hot rvalid return path.
module ct_rd_arb
  import ct_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = CT_ADDR_W,
  parameter int DATA_W  = CT_DATA_W,
  parameter int RD_LAT  = CT_RD_LAT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        rvalid,
  output logic [DATA_W-1:0]         rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [DATA_W-1:0]         mem_rddata,
  output logic                      busy
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]      ptr;
  logic [PW-1:0]      idx;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  addr_sel;
  logic [NUM_REQ-1:0] tag_pipe [RD_LAT];

  rr_pick_nxt #(.N(NUM_REQ)) u_pick (
    .req (req),
    .ptr (ptr),
    .gnt (gnt),
    .idx (idx)
  );

  // NOTE: defaulting every always_comb output first keeps the tool from
  // inferring a latch on paths where no branch assigns it.
  always_comb begin
    addr_sel = addr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  assign mem_addr = addr_sel;

  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      addr_q <= '0;
    end else if (|gnt) begin
      // Explicit wrap keeps non-power-of-two NUM_REQ correct.
      ptr    <= (idx == PW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
      addr_q <= addr_sel;
    end
  end

  // NOTE: the tag pipeline is control state and must be reset so no stale
  // rvalid survives; a data-only memory would not need this.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < RD_LAT; s++) tag_pipe[s] <= '0;
    end else begin
      tag_pipe[0] <= gnt;
      for (int s = 1; s < RD_LAT; s++) tag_pipe[s] <= tag_pipe[s-1];
    end
  end

  assign rvalid = tag_pipe[RD_LAT-1];
  assign rdata  = mem_rddata;

  always_comb begin
    busy = |gnt;
    for (int s = 0; s < RD_LAT; s++) busy = busy | (|tag_pipe[s]);
  end

  req_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(req));

endmodule

// File: tb/tb_ct_rd_arb.sv
// Scoreboard bench for ct_rd_arb: a 2-engine/latency-1 instance and a
// 3-engine/latency-3 instance, each fed by a behavioural ct_mem model.
module tb_ct_rd_arb;

  typedef struct {
    logic [7:0] onehot;
    logic [7:0] data;
    int         due;
  } exp_t;

  localparam logic [2:0] SEQ3 [3] = '{3'b001, 3'b010, 3'b100};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int busy3_exp = -1;
  bit idle_chk  = 1'b0;

  exp_t sb2[$];
  exp_t sb3[$];
  exp_t e2, e3;

  // 2 engines, latency 1
  logic [1:0]  req2, gnt2, rvalid2;
  logic [15:0] req_addr2;
  logic [7:0]  rdata2, mem_addr2, rddata2;
  logic        busy2;

  // 3 engines, latency 3
  logic [2:0]  req3, gnt3, rvalid3;
  logic [23:0] req_addr3;
  logic [7:0]  rdata3, mem_addr3, rddata3;
  logic        busy3;

  ct_rd_arb #(.NUM_REQ(2), .ADDR_W(8), .DATA_W(8), .RD_LAT(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .req_addr(req_addr2), .gnt(gnt2),
    .rvalid(rvalid2), .rdata(rdata2), .mem_addr(mem_addr2),
    .mem_rddata(rddata2), .busy(busy2)
  );

  ct_rd_arb #(.NUM_REQ(3), .ADDR_W(8), .DATA_W(8), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_addr(req_addr3), .gnt(gnt3),
    .rvalid(rvalid3), .rdata(rdata3), .mem_addr(mem_addr3),
    .mem_rddata(rddata3), .busy(busy3)
  );

  // ct_mem model: registered address, data RD_LAT cycles after the address.
  logic [7:0] mem [256];
  initial for (int a = 0; a < 256; a++) mem[a] = 8'(a * 7 + 60);

  logic [7:0] q2;
  logic [7:0] q3 [3];
  always @(posedge clk) begin
    q2    <= mem[mem_addr2];
    q3[0] <= mem[mem_addr3];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign rddata2 = q2;
  assign rddata3 = q3[2];

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of requests, check the combinational grant, and queue the
  // expected return for every engine the bench expects to be granted.
  task automatic step(input logic [1:0] r2, input logic [15:0] a2, input logic [1:0] g2,
                      input logic [2:0] r3, input logic [23:0] a3, input logic [2:0] g3);
    req2 = r2; req_addr2 = a2;
    req3 = r3; req_addr3 = a3;
    @(negedge clk);
    check(gnt2 == g2, "gnt2", gnt2, g2);
    check(gnt3 == g3, "gnt3", gnt3, g3);
    if (busy3_exp >= 0) check(busy3 == busy3_exp[0], "busy3", busy3, busy3_exp);
    if (idle_chk) begin
      check(mem_addr2 == 8'h05, "idle_mem_addr2", mem_addr2, 8'h05);
      check(rvalid2 == 2'b00, "idle_rvalid2", rvalid2, 0);
    end
    for (int e = 0; e < 2; e++)
      if (g2[e]) sb2.push_back('{8'(1) << e, mem[a2[e*8 +: 8]], cyc + 1});
    for (int e = 0; e < 3; e++)
      if (g3[e]) sb3.push_back('{8'(1) << e, mem[a3[e*8 +: 8]], cyc + 3});
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops and compares whenever a DUT presents rvalid.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rvalid2 != 2'b00) begin
        if (sb2.size() == 0) check(1'b0, "rvalid2_unexpected", rvalid2, 0);
        else begin
          e2 = sb2.pop_front();
          check(rvalid2 == e2.onehot[1:0], "rvalid2_tag", rvalid2, e2.onehot);
          check(rdata2 == e2.data, "rdata2", rdata2, e2.data);
          check(cyc == e2.due, "rvalid2_latency", cyc, e2.due);
        end
      end else if (sb2.size() > 0 && sb2[0].due <= cyc) begin
        e2 = sb2.pop_front();
        check(1'b0, "rvalid2_missing", rvalid2, e2.onehot);
      end
      if (rvalid3 != 3'b000) begin
        if (sb3.size() == 0) check(1'b0, "rvalid3_unexpected", rvalid3, 0);
        else begin
          e3 = sb3.pop_front();
          check(rvalid3 == e3.onehot[2:0], "rvalid3_tag", rvalid3, e3.onehot);
          check(rdata3 == e3.data, "rdata3", rdata3, e3.data);
          check(cyc == e3.due, "rvalid3_latency", cyc, e3.due);
        end
      end else if (sb3.size() > 0 && sb3[0].due <= cyc) begin
        e3 = sb3.pop_front();
        check(1'b0, "rvalid3_missing", rvalid3, e3.onehot);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req2 = '0; req_addr2 = '0;
    req3 = '0; req_addr3 = '0;
    #1;
    check(rvalid2 == 2'b00, "reset_rvalid2", rvalid2, 0);
    check(busy2 == 1'b0, "reset_busy2", busy2, 0);
    check(rvalid3 == 3'b000, "reset_rvalid3", rvalid3, 0);
    check(busy3 == 1'b0, "reset_busy3", busy3, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single requester, back-to-back addresses 0..3.
    for (int i = 0; i < 4; i++)
      step(2'b01, {8'h00, 8'(i)}, 2'b01, 3'b000, 24'h0, 3'b000);
    step(2'b00, 16'h0, 2'b00, 3'b000, 24'h0, 3'b000);

    // Two engines contend from reset: strict alternation.
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step(2'b11, {8'h20, 8'h10}, (i % 2 == 0) ? 2'b01 : 2'b10, 3'b000, 24'h0, 3'b000);

    // Pointer wraps after a grant to e1, so e0 wins the next contention.
    step(2'b10, {8'h20, 8'h10}, 2'b10, 3'b000, 24'h0, 3'b000);
    step(2'b11, {8'h20, 8'h10}, 2'b01, 3'b000, 24'h0, 3'b000);

    // Grant at 0x05, then 10 idle cycles with a changed req_addr.
    step(2'b01, {8'hEE, 8'h05}, 2'b01, 3'b000, 24'h0, 3'b000);
    step(2'b00, 16'hEEEE, 2'b00, 3'b000, 24'h0, 3'b000);
    idle_chk = 1'b1;
    repeat (9) step(2'b00, 16'hEEEE, 2'b00, 3'b000, 24'h0, 3'b000);
    idle_chk = 1'b0;

    // Three engines, latency 3, all requesting address i continuously.
    busy3_exp = 1;
    for (int i = 0; i < 6; i++)
      step(2'b00, 16'h0, 2'b00, 3'b111, 24'h020100, SEQ3[i % 3]);
    repeat (3) step(2'b00, 16'h0, 2'b00, 3'b000, 24'h020100, 3'b000);
    busy3_exp = 0;
    step(2'b00, 16'h0, 2'b00, 3'b000, 24'h020100, 3'b000);
    busy3_exp = -1;

    // Reset with tags in flight on both instances.
    for (int i = 0; i < 4; i++)
      step(2'b01, {8'h20, 8'h10}, 2'b01, 3'b111, 24'h020100, SEQ3[i % 3]);
    req2 = '0; req3 = '0;
    rst_n = 1'b0;
    sb2.delete();
    sb3.delete();
    #1;
    check(rvalid2 == 2'b00, "midrst_rvalid2", rvalid2, 0);
    check(busy2 == 1'b0, "midrst_busy2", busy2, 0);
    check(rvalid3 == 3'b000, "midrst_rvalid3", rvalid3, 0);
    check(busy3 == 1'b0, "midrst_busy3", busy3, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(2'b11, {8'h20, 8'h10}, 2'b01, 3'b111, 24'h020100, 3'b001);
    repeat (4) step(2'b00, 16'h0, 2'b00, 3'b000, 24'h0, 3'b000);

    check(sb2.size() == 0, "sb2_drained", sb2.size(), 0);
    check(sb3.size() == 0, "sb3_drained", sb3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
